// File: rtl/sdram_sched_pkg.sv
// Shared encodings for the SDRAM burst scheduler: engine command types and FSM states.
package sdram_sched_pkg;

   typedef enum logic [1:0] {
      CMD_NONE = 2'b00,
      CMD_WR   = 2'b01,
      CMD_RD   = 2'b10,
      CMD_REF  = 2'b11
   } cmd_type_t;

   typedef enum logic [1:0] {
      S_INIT  = 2'b00,
      S_IDLE  = 2'b01,
      S_ISSUE = 2'b10,
      S_BUSY  = 2'b11
   } state_t;

endpackage

// File: rtl/sdram_ref_timer.sv
// Auto-refresh interval timer: raises ref_pending every REF_CYCLES enabled cycles and
// flags a sticky overrun when an interval expires before the previous refresh was served.
module sdram_ref_timer #(
   parameter int REF_CYCLES = 390
) (
   input  logic clk_50m,
   input  logic rst_n,
   input  logic en,
   input  logic ref_clr,
   output logic ref_pending,
   output logic ref_overrun
);

   localparam int CNT_W = $clog2(REF_CYCLES + 1);

   logic [CNT_W-1:0] cnt_r;
   logic             pending_r;
   logic             overrun_r;
   logic             tc_s;

   assign tc_s = en && (cnt_r == CNT_W'(REF_CYCLES - 1));

   // Interval counter, pending flag (a new expiry wins over a same-cycle clear) and overrun.
   always_ff @(posedge clk_50m or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r     <= {CNT_W{1'b0}};
         pending_r <= 1'b0;
         overrun_r <= 1'b0;
      end else begin
         if (!en || tc_s) begin
            cnt_r <= {CNT_W{1'b0}};
         end else begin
            cnt_r <= cnt_r + CNT_W'(1);
         end
         if (tc_s) begin
            pending_r <= 1'b1;
         end else if (ref_clr) begin
            pending_r <= 1'b0;
         end else begin
            pending_r <= pending_r;
         end
         if (tc_s && pending_r && !ref_clr) begin
            overrun_r <= 1'b1;
         end else begin
            overrun_r <= overrun_r;
         end
      end
   end

   assign ref_pending = pending_r;
   assign ref_overrun = overrun_r;

endmodule

// File: rtl/sdram_burst_sched.sv
// Burst scheduler between the user FIFOs and the SDRAM command engine: arbitrates refresh,
// write and read bursts, one outstanding command at a time, with wrapping burst addresses.
module sdram_burst_sched
   import sdram_sched_pkg::*;
#(
   parameter int ADDR_W     = 24,
   parameter int LVL_W      = 10,
   parameter int BURST_LEN  = 128,
   parameter int WR_MIN     = 0,
   parameter int WR_MAX     = 1024,
   parameter int RD_MIN     = 0,
   parameter int RD_MAX     = 1024,
   parameter int REF_CYCLES = 390
) (
   input  logic              clk_50m,
   input  logic              rst_n,
   input  logic              sdram_init_done,
   input  logic              rd_enable,
   input  logic [LVL_W-1:0]  wrf_level,
   input  logic [LVL_W-1:0]  rdf_level,
   output logic              cmd_valid,
   output logic [1:0]        cmd_type,
   output logic [ADDR_W-1:0] cmd_addr,
   output logic [LVL_W-1:0]  cmd_len,
   input  logic              cmd_ready,
   input  logic              cmd_done,
   output logic              ref_overrun
);

   localparam logic [LVL_W:0]    WR_THRESH = (LVL_W + 1)'(BURST_LEN);
   localparam logic [LVL_W:0]    RD_THRESH = (LVL_W + 1)'((2 ** LVL_W) - BURST_LEN);
   localparam logic [ADDR_W:0]   BURST_A   = (ADDR_W + 1)'(BURST_LEN);
   localparam logic [ADDR_W:0]   WR_MAX_A  = (ADDR_W + 1)'(WR_MAX);
   localparam logic [ADDR_W:0]   RD_MAX_A  = (ADDR_W + 1)'(RD_MAX);
   localparam logic [ADDR_W-1:0] WR_MIN_A  = ADDR_W'(WR_MIN);
   localparam logic [ADDR_W-1:0] RD_MIN_A  = ADDR_W'(RD_MIN);

   logic              sync1_r;
   logic              init_sync_r;
   state_t            state_r;
   cmd_type_t         cur_op_r;
   cmd_type_t         last_op_r;
   logic [ADDR_W-1:0] wr_addr_r;
   logic [ADDR_W-1:0] rd_addr_r;
   logic              cmd_valid_r;
   cmd_type_t         cmd_type_r;
   logic [ADDR_W-1:0] cmd_addr_r;
   logic [LVL_W-1:0]  cmd_len_r;

   logic              wr_ok_s;
   logic              rd_ok_s;
   cmd_type_t         sel_s;
   logic [ADDR_W:0]   wr_sum_s;
   logic [ADDR_W:0]   rd_sum_s;
   logic [ADDR_W-1:0] wr_next_s;
   logic [ADDR_W-1:0] rd_next_s;
   logic [ADDR_W-1:0] issue_addr_s;
   logic              ref_pending_s;
   logic              ref_clr_s;

   // Two-flop synchronizer for the asynchronous init-complete flag.
   always_ff @(posedge clk_50m or negedge rst_n) begin
      if (!rst_n) begin
         sync1_r     <= 1'b0;
         init_sync_r <= 1'b0;
      end else begin
         sync1_r     <= sdram_init_done;
         init_sync_r <= sync1_r;
      end
   end

   assign wr_ok_s   = ({1'b0, wrf_level} >= WR_THRESH);
   assign rd_ok_s   = rd_enable && ({1'b0, rdf_level} <= RD_THRESH);
   assign wr_sum_s  = {1'b0, wr_addr_r} + BURST_A;
   assign rd_sum_s  = {1'b0, rd_addr_r} + BURST_A;
   assign ref_clr_s = (state_r == S_BUSY) && cmd_done && (cur_op_r == CMD_REF);

   // Arbitration (refresh first, then write/read alternating) and wrapped next addresses.
   always_comb begin
      sel_s        = CMD_NONE;
      wr_next_s    = wr_sum_s[ADDR_W-1:0];
      rd_next_s    = rd_sum_s[ADDR_W-1:0];
      issue_addr_s = {ADDR_W{1'b0}};
      if (ref_pending_s) begin
         sel_s = CMD_REF;
      end else if (wr_ok_s && rd_ok_s) begin
         sel_s = (last_op_r == CMD_WR) ? CMD_RD : CMD_WR;
      end else if (wr_ok_s) begin
         sel_s = CMD_WR;
      end else if (rd_ok_s) begin
         sel_s = CMD_RD;
      end else begin
         sel_s = CMD_NONE;
      end
      if (wr_sum_s >= WR_MAX_A) begin
         wr_next_s = WR_MIN_A;
      end else begin
         wr_next_s = wr_sum_s[ADDR_W-1:0];
      end
      if (rd_sum_s >= RD_MAX_A) begin
         rd_next_s = RD_MIN_A;
      end else begin
         rd_next_s = rd_sum_s[ADDR_W-1:0];
      end
      case (sel_s)
         CMD_WR:  issue_addr_s = wr_addr_r;
         CMD_RD:  issue_addr_s = rd_addr_r;
         default: issue_addr_s = {ADDR_W{1'b0}};
      endcase
   end

   // Scheduler FSM with registered command outputs and burst address generators.
   always_ff @(posedge clk_50m or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= S_INIT;
         cur_op_r    <= CMD_NONE;
         last_op_r   <= CMD_RD;
         wr_addr_r   <= WR_MIN_A;
         rd_addr_r   <= RD_MIN_A;
         cmd_valid_r <= 1'b0;
         cmd_type_r  <= CMD_NONE;
         cmd_addr_r  <= {ADDR_W{1'b0}};
         cmd_len_r   <= {LVL_W{1'b0}};
      end else begin
         case (state_r)
            S_INIT: begin
               cmd_valid_r <= 1'b0;
               cmd_type_r  <= CMD_NONE;
               state_r     <= init_sync_r ? S_IDLE : S_INIT;
            end
            S_IDLE: begin
               if (!init_sync_r) begin
                  state_r <= S_INIT;
               end else if (sel_s != CMD_NONE) begin
                  cmd_valid_r <= 1'b1;
                  cmd_type_r  <= sel_s;
                  cur_op_r    <= sel_s;
                  cmd_addr_r  <= issue_addr_s;
                  cmd_len_r   <= (sel_s == CMD_REF) ? {LVL_W{1'b0}} : LVL_W'(BURST_LEN);
                  state_r     <= S_ISSUE;
               end else begin
                  state_r <= S_IDLE;
               end
            end
            S_ISSUE: begin
               if (!init_sync_r) begin
                  cmd_valid_r <= 1'b0;
                  cmd_type_r  <= CMD_NONE;
                  cmd_addr_r  <= {ADDR_W{1'b0}};
                  cmd_len_r   <= {LVL_W{1'b0}};
                  state_r     <= S_INIT;
               end else if (cmd_ready) begin
                  cmd_valid_r <= 1'b0;
                  cmd_type_r  <= CMD_NONE;
                  state_r     <= S_BUSY;
               end else begin
                  state_r <= S_ISSUE;
               end
            end
            S_BUSY: begin
               if (cmd_done) begin
                  case (cur_op_r)
                     CMD_WR: begin
                        wr_addr_r <= wr_next_s;
                        last_op_r <= CMD_WR;
                     end
                     CMD_RD: begin
                        rd_addr_r <= rd_next_s;
                        last_op_r <= CMD_RD;
                     end
                     default: last_op_r <= last_op_r;
                  endcase
                  state_r <= init_sync_r ? S_IDLE : S_INIT;
               end else begin
                  state_r <= S_BUSY;
               end
            end
            default: state_r <= S_INIT;
         endcase
      end
   end

   sdram_ref_timer #(
      .REF_CYCLES (REF_CYCLES)
   ) u_ref_timer (
      .clk_50m     (clk_50m),
      .rst_n       (rst_n),
      .en          (init_sync_r),
      .ref_clr     (ref_clr_s),
      .ref_pending (ref_pending_s),
      .ref_overrun (ref_overrun)
   );

   assign cmd_valid = cmd_valid_r;
   assign cmd_type  = cmd_type_r;
   assign cmd_addr  = cmd_addr_r;
   assign cmd_len   = cmd_len_r;

endmodule
